// File: rtl/uart_tx_fifo.sv
// Buffered transmit front-end for UART_Module: a circular byte FIFO drained
// one byte at a time through a start/busy/complete handshake.
module uart_tx_fifo #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_en,
    input  logic              ovf_clr,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    input  logic              tx_complete_flag,
    output logic              tx_complete_del_flag,
    output logic              idle
);

    localparam logic [ADDR_W:0]   DEPTH   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_DONE,
        ACK
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_next;
    logic              push;
    logic              pop;

    assign push = wr_en && !full;
    assign pop  = (state == IDLE) && (state_next == LOAD);
    assign idle = (state == IDLE) && empty;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CNT_ONE;
        end else if (pop && !push) begin
            count_next = count - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // The byte is fetched on entry to LOAD, so tx_data is already valid
    // while LOAD is held and stays put until the next pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
            tx_data  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + PTR_ONE;
                tx_data <= mem[rd_ptr];
            end
            count <= count_next;
            full  <= (count_next == DEPTH);
            empty <= (count_next == '0);
            if (wr_en && full) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next           = state;
        tx_start             = 1'b0;
        tx_complete_del_flag = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !tx_busy && !tx_complete_flag) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                state_next = START;
            end
            START: begin
                tx_start = 1'b1;
                if (tx_busy || tx_complete_flag) begin
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (tx_complete_flag) begin
                    state_next = ACK;
                end
            end
            ACK: begin
                tx_complete_del_flag = 1'b1;
                if (!tx_complete_flag) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a behavioural UART transmitter model.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] wr_data = '0;
    logic       wr_en = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       tx_complete_flag = 1'b0;
    logic       tx_complete_del_flag;
    logic       idle;

    logic        model_busy = 1'b0;
    logic        hold_busy = 1'b0;
    int unsigned frame_len = 100;
    int          m_state = 0;
    int unsigned m_cnt = 0;
    logic [7:0]  seen [$];
    int unsigned start_rises = 0;
    int unsigned start_during_flag = 0;
    logic        start_prev = 1'b0;

    int compared = 0;
    int mismatched = 0;

    assign tx_busy = model_busy | hold_busy;

    uart_tx_fifo #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .wr_data              (wr_data),
        .wr_en                (wr_en),
        .ovf_clr              (ovf_clr),
        .full                 (full),
        .empty                (empty),
        .count                (count),
        .overflow             (overflow),
        .tx_data              (tx_data),
        .tx_start             (tx_start),
        .tx_busy              (tx_busy),
        .tx_complete_flag     (tx_complete_flag),
        .tx_complete_del_flag (tx_complete_del_flag),
        .idle                 (idle)
    );

    always #5 clk = ~clk;

    // UART model: busy 2 cycles after the request, completion flag frame_len later.
    always @(negedge clk) begin
        if (!reset_n) begin
            m_state          = 0;
            m_cnt            = 0;
            model_busy       = 1'b0;
            tx_complete_flag = 1'b0;
            start_prev       = 1'b0;
        end else begin
            if (tx_start && !start_prev) start_rises++;
            if (tx_start && tx_complete_flag) start_during_flag++;
            start_prev = tx_start;
            case (m_state)
                0: if (tx_start) begin
                    seen.push_back(tx_data);
                    m_cnt   = 0;
                    m_state = 1;
                end
                1: begin
                    m_cnt++;
                    if (m_cnt == 2) begin
                        model_busy = 1'b1;
                        m_cnt      = 0;
                        m_state    = 2;
                    end
                end
                2: begin
                    m_cnt++;
                    if (m_cnt == frame_len) begin
                        model_busy       = 1'b0;
                        tx_complete_flag = 1'b1;
                        m_state          = 3;
                    end
                end
                default: if (tx_complete_del_flag) begin
                    tx_complete_flag = 1'b0;
                    m_state          = 0;
                end
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_captures(input int n, input int limit, input string name);
        int k = 0;
        while (seen.size() < n && k < limit) begin
            tick();
            k++;
        end
        check(name, 32'(seen.size() >= n), 32'd1);
    endtask

    task automatic wait_idle(input int limit, input string name);
        int k = 0;
        while (!idle && k < limit) begin
            tick();
            k++;
        end
        check(name, 32'(idle), 32'd1);
    endtask

    typedef struct {
        logic       wr_en;
        logic [7:0] data;
        logic       ovf_clr;
        logic [4:0] count;
        logic       full;
        logic       empty;
        logic       ovf;
    } vec_t;

    vec_t vecs [20];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  exp_q [$];
        int unsigned rises0;
        int          k;
        int          viol;

        for (int i = 0; i < 16; i++) begin
            vecs[i].wr_en   = 1'b1;
            vecs[i].data    = 8'hA0 + 8'(i);
            vecs[i].ovf_clr = 1'b0;
            vecs[i].count   = 5'(i + 1);
            vecs[i].full    = (i == 15);
            vecs[i].empty   = 1'b0;
            vecs[i].ovf     = 1'b0;
        end
        vecs[16] = '{wr_en: 1'b1, data: 8'hEE, ovf_clr: 1'b0, count: 5'd16, full: 1'b1, empty: 1'b0, ovf: 1'b1};
        vecs[17] = '{wr_en: 1'b1, data: 8'hEF, ovf_clr: 1'b1, count: 5'd16, full: 1'b1, empty: 1'b0, ovf: 1'b1};
        vecs[18] = '{wr_en: 1'b0, data: 8'h00, ovf_clr: 1'b1, count: 5'd16, full: 1'b1, empty: 1'b0, ovf: 1'b0};
        vecs[19] = '{wr_en: 1'b0, data: 8'h00, ovf_clr: 1'b0, count: 5'd16, full: 1'b1, empty: 1'b0, ovf: 1'b0};

        // Reset and idle
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        tick();
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_idle", 32'(idle), 32'd1);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_del_flag", 32'(tx_complete_del_flag), 32'd0);

        // Single byte, 3-clock latency to tx_start
        frame_len = 100;
        @(negedge clk);
        wr_en = 1'b1;
        wr_data = 8'h2F;
        tick();
        check("lat1_tx_start", 32'(tx_start), 32'd0);
        @(negedge clk);
        wr_en = 1'b0;
        tick();
        check("lat2_tx_start", 32'(tx_start), 32'd0);
        tick();
        check("lat3_tx_start", 32'(tx_start), 32'd1);
        check("lat3_tx_data", 32'(tx_data), 32'h2F);
        k = 0;
        while (!tx_complete_del_flag && k < 400) begin
            tick();
            k++;
        end
        check("single_del_seen", 32'(tx_complete_del_flag), 32'd1);
        check("single_flag_at_del", 32'(tx_complete_flag), 32'd1);
        viol = 0;
        k = 0;
        while (tx_complete_flag && k < 50) begin
            if (!tx_complete_del_flag) viol++;
            tick();
            k++;
        end
        check("single_flag_dropped", 32'(tx_complete_flag), 32'd0);
        check("single_del_held", 32'(viol), 32'd0);
        check("single_del_clear", 32'(tx_complete_del_flag), 32'd0);
        check("single_idle_after", 32'(idle), 32'd1);

        // Burst order, writes queued behind a busy UART
        frame_len = 6;
        seen.delete();
        rises0 = start_rises;
        @(negedge clk);
        hold_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            wr_en = 1'b1;
            wr_data = 8'(i + 1);
            tick();
            check($sformatf("burst_count%0d", i), 32'(count), 32'(i + 1));
        end
        @(negedge clk);
        wr_en = 1'b0;
        hold_busy = 1'b0;
        wait_captures(5, 500, "burst_timeout");
        for (int i = 0; i < 5; i++) begin
            check($sformatf("burst_byte%0d", i), 32'(seen[i]), 32'(i + 1));
        end
        wait_idle(200, "burst_idle");
        check("burst_start_pulses", start_rises - rises0, 32'd5);
        check("burst_start_vs_flag", start_during_flag, 32'd0);

        // Push and pop in the same cycle
        seen.delete();
        @(negedge clk);
        hold_busy = 1'b1;
        wr_en = 1'b1;
        wr_data = 8'hC1;
        tick();
        @(negedge clk);
        wr_data = 8'hC2;
        tick();
        check("pp_count_before", 32'(count), 32'd2);
        @(negedge clk);
        hold_busy = 1'b0;
        wr_data = 8'hC3;
        tick();
        check("pp_count_same", 32'(count), 32'd2);
        @(negedge clk);
        wr_en = 1'b0;
        tick();
        check("pp_count_load", 32'(count), 32'd2);
        wait_captures(3, 300, "pp_timeout");
        for (int i = 0; i < 3; i++) begin
            check($sformatf("pp_byte%0d", i), 32'(seen[i]), 32'(8'hC1 + 8'(i)));
        end
        wait_idle(200, "pp_idle");

        // Fill to full, overflow and clear, from the vector table
        frame_len = 4;
        seen.delete();
        rises0 = start_rises;
        @(negedge clk);
        hold_busy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            wr_en = vecs[i].wr_en;
            wr_data = vecs[i].data;
            ovf_clr = vecs[i].ovf_clr;
            tick();
            check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].count));
            check($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].full));
            check($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].empty));
            check($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vecs[i].ovf));
        end
        check("fill_no_start", start_rises - rises0, 32'd0);

        // Drain 10, then refill 10 while draining; pointers wrap
        @(negedge clk);
        wr_en = 1'b0;
        ovf_clr = 1'b0;
        hold_busy = 1'b0;
        wait_captures(10, 1000, "wrap_drain_timeout");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            wr_en = 1'b1;
            wr_data = 8'hB0 + 8'(i);
        end
        @(negedge clk);
        wr_en = 1'b0;
        wait_captures(26, 2000, "wrap_timeout");
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(8'hA0 + 8'(i));
        for (int i = 0; i < 10; i++) exp_q.push_back(8'hB0 + 8'(i));
        viol = 0;
        for (int i = 0; i < 26; i++) begin
            if (i >= seen.size() || seen[i] !== exp_q[i]) viol++;
        end
        check("wrap_order_errors", 32'(viol), 32'd0);
        check("wrap_seen_size", 32'(seen.size()), 32'd26);
        check("wrap_overflow", 32'(overflow), 32'd0);
        wait_idle(200, "wrap_idle");
        check("wrap_count_zero", 32'(count), 32'd0);

        // Reset during WAIT_DONE
        frame_len = 100;
        seen.delete();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            wr_en = 1'b1;
            wr_data = 8'hD0 + 8'(i);
        end
        @(negedge clk);
        wr_en = 1'b0;
        k = 0;
        while (!(tx_busy && !tx_start) && k < 50) begin
            tick();
            k++;
        end
        check("mid_wait_done_seen", 32'(tx_busy && !tx_start), 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("mid_count", 32'(count), 32'd0);
        check("mid_empty", 32'(empty), 32'd1);
        check("mid_tx_start", 32'(tx_start), 32'd0);
        check("mid_tx_data", 32'(tx_data), 32'd0);
        check("mid_idle", 32'(idle), 32'd1);
        check("mid_del_flag", 32'(tx_complete_del_flag), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        seen.delete();
        rises0 = start_rises;
        repeat (20) tick();
        check("mid_no_start", start_rises - rises0, 32'd0);
        check("mid_post_count", 32'(count), 32'd0);
        frame_len = 4;
        @(negedge clk);
        wr_en = 1'b1;
        wr_data = 8'hE7;
        @(negedge clk);
        wr_en = 1'b0;
        wait_captures(1, 100, "mid_new_timeout");
        check("mid_new_byte", 32'(seen.size() > 0 ? seen[0] : 8'h00), 32'hE7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Buffered transmit front-end that sits directly upstream of UART_Module's transmit side. It accepts bytes from the host logic into a circular FIFO and drains them one at a time into the UART. It drives tx_data and tx_start, observes tx_busy and tx_complete_flag, and clears the completion flag through tx_complete_del_flag. Host logic can queue a burst of bytes without tracking UART timing.

Parameters:
ADDR_W, 4, FIFO address width; depth = 2**ADDR_W (16 entries)
DATA_W, 8, byte width; must match UART_Module tx_data

Ports:
clk  input  1  system clock (100 MHz in the standard build)
reset_n  input  1  asynchronous active-low reset
wr_data  input  DATA_W  byte to enqueue
wr_en  input  1  enqueue strobe; one byte per cycle while high
ovf_clr  input  1  clears the sticky overflow flag
full  output  1  FIFO holds 2**ADDR_W bytes
empty  output  1  FIFO holds 0 bytes
count  output  ADDR_W+1  current occupancy, 0..2**ADDR_W
overflow  output  1  sticky; set when a write is attempted while full
tx_data  output  DATA_W  byte presented to UART_Module
tx_start  output  1  level request to UART_Module
tx_busy  input  1  from UART_Module
tx_complete_flag  input  1  from UART_Module; high after a frame finishes
tx_complete_del_flag  output  1  to UART_Module; clears tx_complete_flag
idle  output  1  high when FIFO is empty and the state machine is IDLE

Behaviour:
- Reset (async, reset_n=0):
  - wr_ptr=0, rd_ptr=0, count=0, so empty=1 and full=0.
  - overflow=0, tx_data=0, tx_start=0, tx_complete_del_flag=0.
  - State=IDLE, idle=1. Memory contents are don't-care.
- Write path:
  - wr_en=1 with full=0: the memory at wr_ptr is written, wr_ptr increments modulo depth, and count increments.
  - wr_en=1 with full=1: the write is dropped and overflow is set. This applies even if a pop occurs in the same cycle.
  - overflow clears only on ovf_clr=1. If ovf_clr and a dropped write coincide, set wins.
- Pop: occurs only on the IDLE->LOAD transition. rd_ptr increments modulo depth and count decrements.
  - A push and a pop in the same cycle (not full) leave count unchanged.
  - Both pointers wrap from depth-1 to 0.
- Flags:
  - full = (count == depth); empty = (count == 0).
  - Both are registered and derived from the next-state count, so they are valid in the same cycle as count.
- State machine:
  - IDLE: if empty=0, tx_busy=0 and tx_complete_flag=0, go to LOAD. Otherwise stay.
  - LOAD (1 cycle): tx_data <= mem[rd_ptr]; pop. Go to START.
  - START: tx_start=1. Stay until tx_busy=1 or tx_complete_flag=1, then go to WAIT_DONE with tx_start deasserted on that transition.
  - WAIT_DONE: tx_start=0. Stay until tx_complete_flag=1, then go to ACK.
  - ACK: tx_complete_del_flag=1. Stay until tx_complete_flag=0, then go to IDLE.
  - tx_complete_del_flag is low in all states except ACK.
- Timing:
  - tx_data is held stable from LOAD until the next LOAD.
  - Latency from the first write into an empty, idle FIFO to tx_start=1 is 3 clocks: write cycle, IDLE decision, LOAD.
- idle = (state==IDLE) && empty.
- Reset mid-frame: all state returns to reset values immediately, and queued bytes are discarded. UART_Module is reset by the same reset_n, so no partial-frame handshake is completed.
- A write during any state is accepted if not full; the FIFO fill is independent of the drain state.

Test Plan:
- Reset then idle: reset_n low 50 ns, then high -> empty=1, count=0, tx_start=0, idle=1, tx_data=0.
- Single byte: write 8'h2F once, with a UART model that asserts tx_busy 2 cycles after tx_start and raises tx_complete_flag 100 cycles later.
  - tx_start rises 3 clocks after the write, with tx_data=8'h2F.
  - tx_complete_del_flag is high until the model drops tx_complete_flag.
  - Afterwards idle=1.
- Burst order: write 8'h01..8'h05 on consecutive cycles.
  - count peaks at 5.
  - Bytes appear on tx_data in order 01,02,03,04,05, with exactly one tx_start assertion per byte.
  - No tx_start occurs while tx_complete_flag=1.
- Full/overflow: with UART tx_busy held at 1, write 17 bytes.
  - After 16 writes, full=1 and count=16.
  - The 17th write sets overflow=1, count stays 16, and the byte is dropped.
  - ovf_clr pulse -> overflow=0.
- Wrap and simultaneous: fill to 16, then drain 10, then write 10 more while draining.
  - Pointers wrap and the output order matches the write order.
  - A cycle with push and pop together keeps count constant.
- Reset mid-operation: queue 4 bytes and assert reset_n low during WAIT_DONE.
  - Outputs immediately return to reset values and count=0.
  - After release, no tx_start occurs until a new write.
